apb_irq_ctrl: RTL
=================

Name: apb_irq_ctrl

Overview:
- APB-mapped interrupt collector directly downstream of the timer blocks.
- Consumes the per-timer level interrupt lines: overflow and compare for each timer.
- Edge-detects the lines into sticky pending bits, applies a per-source mask, reports overruns and the highest-priority source ID, and drives one combined interrupt line to the core.
- Sits on the same APB segment as the timers; same bus rules: always ready, no error response.

Parameters:
- APB_ADDR_WIDTH, 12, APB address width (4KB slave window).
- N_SRC, 4, number of interrupt sources (2 timers x {overflow, compare}); legal range 1..32.

Ports:
- HCLK  input  1  clock; all state updates on its rising edge.
- HRESET  input  1  reset; synchronous, active-high.
- PADDR  input  APB_ADDR_WIDTH  APB address.
- PWDATA  input  32  APB write data.
- PWRITE  input  1  APB write strobe.
- PSEL  input  1  APB select.
- PENABLE  input  1  APB access phase.
- PRDATA  output  32  APB read data.
- PREADY  output  1  tied 1.
- PSLVERR  output  1  tied 0.
- irq_i  input  N_SRC  level interrupt lines from timers; bit 2k = timer k overflow, bit 2k+1 = timer k compare.
- irq_o  output  1  combined interrupt to core.

Behaviour:
- Register select is PADDR[4:2]. Access occurs when PSEL && PENABLE. Bits above N_SRC-1 read 0 and ignore writes.
- Register map:
  - 0x00 PENDING: read returns pending bits; write-1-to-clear.
  - 0x04 MASK: read/write; 1 = source enabled.
  - 0x08 STATUS: read-only; pending & mask.
  - 0x0C CTRL: bit0 GEN (global enable); bit1 PULSE mode (0 = level, 1 = one-cycle pulse). Other bits read 0.
  - 0x10 OVERRUN: sticky, write-1-to-clear; set when an edge arrives on a source whose pending bit is already 1.
  - 0x14 ID: read-only. bit31 = VALID (STATUS != 0); bits[4:0] = lowest-index set STATUS bit, 0 when not VALID.
  - Other offsets: read 0, writes ignored.
- PRDATA is 0 unless a read access is in progress. It is combinational from the registered state.
- Edge detect: irq_q <= irq_i every cycle; edge = irq_i & ~irq_q. A level held high for many cycles sets pending once.
- Pending update per bit: next = (pending & ~clr) | edge, where clr is the W1C write data. Set wins over a simultaneous clear, so no event is lost.
- OVERRUN update: set on edge & pending (pending value before this cycle's clear). Clear via W1C; a simultaneous set wins.
- Latency: irq_i rises in cycle t; pending is visible at edge t+1. In level mode irq_o is high in cycle t+1.
- Level mode: irq_o = GEN && |STATUS, decoded from registered state.
- Pulse mode: irq_o is a registered one-cycle pulse on the 0->1 transition of (GEN && |STATUS). It re-pulses only after that term has returned to 0.
- Writing MASK or GEN to 1 while pending bits exist makes irq_o assert (level) or pulse on the next cycle.
- Reset (HRESET high at an edge):
  - pending, MASK, CTRL, OVERRUN, irq_q and the pulse state all go to 0.
  - irq_o = 0 and PRDATA = 0.
  - Reset has priority over any APB access in the same cycle.
  - A source that is high when reset is released counts as an edge on the first post-reset cycle.
- Wrap/saturation: none. All state is sticky bits only.

Decomposition:
- Shared package apb_irq_pkg holds:
  - register offsets, as 3-bit index constants;
  - CTRL bit positions GEN_BIT and PULSE_BIT;
  - ID_VALID_BIT;
  - MAX_SRC = 32.
- One natural sub-module: irq_prio_enc. It is a parameterised lowest-index priority encoder taking an N_SRC vector and producing a 5-bit index plus a valid flag. It is reused for the ID register.

Test Plan:
- Reset, then read all registers -> every register is 0x0000_0000 and irq_o = 0.
- MASK=0x1, CTRL=0x1; drive irq_i=0x1 for 5 cycles -> PENDING=0x1, irq_o high one cycle after the rise, ID=0x8000_0000. Write PENDING=0x1 -> irq_o drops the next cycle and PENDING=0x0.
- MASK=0x0, GEN=1; pulse irq_i[3] -> PENDING=0x8, STATUS=0x0, irq_o=0. Then write MASK=0x8 -> irq_o=1 next cycle, ID=0x8000_0003.
- Pulse irq_i[1] twice without clearing -> PENDING=0x2, OVERRUN=0x2. Write OVERRUN=0x2 -> OVERRUN=0x0.
- Edge on irq_i[2] in the same cycle as a W1C write of PENDING=0x4 -> PENDING stays 0x4.
- CTRL=0x3, MASK=0xF; raise irq_i[0] then irq_i[2] -> exactly one irq_o pulse while STATUS stays nonzero. Clear all, then raise irq_i[1] -> a second pulse.

Source files
------------

// File: rtl/apb_irq_pkg.sv
// apb_irq_pkg: register indices and bit positions shared by the interrupt collector
package apb_irq_pkg;
  localparam logic [2:0] REG_PENDING = 3'd0;
  localparam logic [2:0] REG_MASK    = 3'd1;
  localparam logic [2:0] REG_STATUS  = 3'd2;
  localparam logic [2:0] REG_CTRL    = 3'd3;
  localparam logic [2:0] REG_OVERRUN = 3'd4;
  localparam logic [2:0] REG_ID      = 3'd5;
  localparam int GEN_BIT      = 0;
  localparam int PULSE_BIT    = 1;
  localparam int ID_VALID_BIT = 31;
  localparam int MAX_SRC      = 32;
endpackage

// File: rtl/apb_irq_ctrl_if.sv
// apb_irq_ctrl_if: APB slave bus bundle for the interrupt collector
interface apb_irq_ctrl_if #(parameter int APB_ADDR_WIDTH = 12);
  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic PWRITE;
  logic PSEL;
  logic PENABLE;
  logic PREADY;
  logic PSLVERR;
  modport master(output PADDR, PWDATA, PWRITE, PSEL, PENABLE, input PRDATA, PREADY, PSLVERR);
  modport slave(input PADDR, PWDATA, PWRITE, PSEL, PENABLE, output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: lowest-index priority encoder with valid flag
module irq_prio_enc #(
  parameter int N_SRC = 4
) (
  input  logic [N_SRC-1:0] vec,
  output logic [4:0]       idx,
  output logic             valid
);
  // scan from the top down so the lowest set bit is the last to win
  always_comb begin
    idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) idx = vec[i] ? 5'(i) : idx;
  end
  assign valid = |vec;
endmodule

// File: rtl/apb_irq_ctrl.sv
// apb_irq_ctrl: edge-detecting sticky interrupt collector with mask, overrun and ID on APB
module apb_irq_ctrl
  import apb_irq_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int N_SRC          = 4
) (
  input  logic             HCLK,
  input  logic             HRESET,
  apb_irq_ctrl_if.slave    bus,
  input  logic [N_SRC-1:0] irq_i,
  output logic             irq_o
);
  logic [N_SRC-1:0] pending, mask, ovr, irq_q, rise, status;
  logic [N_SRC-1:0] pend_n, mask_n, ovr_n, clr, oclr;
  logic             gen, pulse, gen_n, pulse_n, act, act_n, irq_pulse;
  logic [2:0]       idx;
  logic             wr, rd, id_valid;
  logic [4:0]       id;
  logic [31:0]      ctrl_rd, id_rd;

  assign idx    = bus.PADDR[4:2];
  assign wr     = bus.PSEL && bus.PENABLE && bus.PWRITE;
  assign rd     = bus.PSEL && bus.PENABLE && !bus.PWRITE;
  assign rise   = irq_i & ~irq_q;
  assign status = pending & mask;
  assign act    = gen && |status;

  irq_prio_enc #(.N_SRC(N_SRC)) u_enc (.vec(status), .idx(id), .valid(id_valid));

  // next state: new edges win over simultaneous W1C clears so no event is lost
  always_comb begin
    clr     = (wr && idx == REG_PENDING) ? bus.PWDATA[N_SRC-1:0] : '0;
    oclr    = (wr && idx == REG_OVERRUN) ? bus.PWDATA[N_SRC-1:0] : '0;
    pend_n  = (pending & ~clr) | rise;
    ovr_n   = (ovr & ~oclr) | (rise & pending);
    mask_n  = (wr && idx == REG_MASK) ? bus.PWDATA[N_SRC-1:0] : mask;
    gen_n   = (wr && idx == REG_CTRL) ? bus.PWDATA[GEN_BIT] : gen;
    pulse_n = (wr && idx == REG_CTRL) ? bus.PWDATA[PULSE_BIT] : pulse;
    act_n   = gen_n && |(pend_n & mask_n);
  end

  // state registers; the pulse flop fires in the same cycle the level output would rise
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      pending   <= '0;
      mask      <= '0;
      ovr       <= '0;
      irq_q     <= '0;
      gen       <= 1'b0;
      pulse     <= 1'b0;
      irq_pulse <= 1'b0;
    end else begin
      pending   <= pend_n;
      mask      <= mask_n;
      ovr       <= ovr_n;
      irq_q     <= irq_i;
      gen       <= gen_n;
      pulse     <= pulse_n;
      irq_pulse <= act_n && !act;
    end
  end

  // CTRL and ID read images assembled from their bit positions
  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[GEN_BIT] = gen;
    ctrl_rd[PULSE_BIT] = pulse;
    id_rd = '0;
    id_rd[4:0] = id;
    id_rd[ID_VALID_BIT] = id_valid;
  end

  assign bus.PRDATA  = !rd                  ? '0 :
                       idx == REG_PENDING  ? 32'(pending) :
                       idx == REG_MASK     ? 32'(mask) :
                       idx == REG_STATUS   ? 32'(status) :
                       idx == REG_CTRL     ? ctrl_rd :
                       idx == REG_OVERRUN  ? 32'(ovr) :
                       idx == REG_ID       ? id_rd : '0;
  assign bus.PREADY  = 1'b1;
  assign bus.PSLVERR = 1'b0;
  assign irq_o       = pulse ? irq_pulse : act;
endmodule
